// File: rtl/field_extractor_pkg.sv
// Shared types and constants for the field extractor: bus widths, FSM states, config word layout.
package field_extractor_pkg;

  localparam int WORD_WIDTH   = 32;
  localparam int NUM_HEADERS  = 4;
  localparam int HDR_IDX_W    = 2;
  localparam int ADDR_BUS     = 16;
  localparam int DATA_BUS     = 32;
  localparam int FE_STATE_BUS = 2;

  localparam logic [WORD_WIDTH-1:0] NO_HEADER = '1;

  typedef enum logic [FE_STATE_BUS-1:0] {
    FE_STATE_FREE = 2'd0,
    FE_STATE_SCAN = 2'd1,
    FE_STATE_WAIT = 2'd2,
    FE_STATE_DONE = 2'd3
  } fe_state_e;

  // Config word: [31:24] hdr_id, [23:8] byte offset, [2:0] width in bytes.
  typedef struct packed {
    logic [7:0]  hdr_id;
    logic [15:0] offset;
    logic [4:0]  rsvd;
    logic [2:0]  width;
  } fe_cfg_t;

  function automatic logic width_ok(input logic [2:0] w);
    return (w >= 3'd1) && (w <= 3'd4);
  endfunction

  function automatic logic [WORD_WIDTH-1:0] width_mask(input logic [2:0] w);
    logic [WORD_WIDTH-1:0] m;
    case (w)
      3'd1:    m = 32'h0000_00FF;
      3'd2:    m = 32'h0000_FFFF;
      3'd3:    m = 32'h00FF_FFFF;
      3'd4:    m = 32'hFFFF_FFFF;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/field_extractor_cfg_regs.sv
// Field slot configuration register file: gated write, combinational read, async active-low clear.
module field_extractor_cfg_regs
  import field_extractor_pkg::*;
#(
  parameter int NUM_FIELDS = 4,
  parameter int IDX_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [WORD_WIDTH-1:0] wr_data,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [WORD_WIDTH-1:0] rd_data
);

  logic [WORD_WIDTH-1:0] slots [NUM_FIELDS];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_FIELDS; k++) begin
        slots[k] <= '0;
      end
    end else if (we) begin
      slots[wr_idx] <= wr_data;
    end
  end

  assign rd_data = slots[rd_idx];

endmodule

// File: rtl/field_extractor.sv
// Walks the configured field slots, fetches each field from packet memory and packs them into a key.
// Optional bounds check on fetch addresses is enabled by defining FE_BOUNDS_CHECK_EN.
module field_extractor
  import field_extractor_pkg::*;
#(
  parameter  int NUM_FIELDS  = 4,
  parameter  int PKT_MAX_LEN = 1518,
  localparam int IDX_W       = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic [WORD_WIDTH*NUM_HEADERS-1:0] parsed_hdrs_i,
  input  logic                              cfg_we_i,
  input  logic [IDX_W-1:0]                  cfg_idx_i,
  input  logic [WORD_WIDTH-1:0]             cfg_data_i,
  output logic                              mem_ce_o,
  output logic                              mem_we_o,
  output logic [ADDR_BUS-1:0]               mem_addr_o,
  output logic [3:0]                        mem_width_o,
  output logic [DATA_BUS-1:0]               mem_data_o,
  input  logic [DATA_BUS-1:0]               mem_data_i,
  output logic                              extract_ready_o,
  output logic [WORD_WIDTH*NUM_FIELDS-1:0]  fields_o,
  output logic [NUM_FIELDS-1:0]             field_vld_o,
  output logic                              err_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FIELDS - 1);
  localparam logic [7:0]       NUM_HDRS = 8'(NUM_HEADERS);

  fe_state_e                                   state_q, state_d;
  logic [IDX_W-1:0]                            idx_q, idx_d;
  logic [0:NUM_HEADERS-1][WORD_WIDTH-1:0]      hdrs_q, hdrs_d;
  logic [0:NUM_FIELDS-1][WORD_WIDTH-1:0]       lanes_q, lanes_d;
  logic [NUM_FIELDS-1:0]                       vld_q, vld_d;
  logic                                        ready_q, ready_d;
  logic                                        ce_q, ce_d;
  logic [ADDR_BUS-1:0]                         addr_q, addr_d;
  logic [3:0]                                  width_q, width_d;

  logic [WORD_WIDTH-1:0] cfg_word;
  fe_cfg_t               cfg;
  logic                  cfg_wr_en;
  logic [WORD_WIDTH-1:0] hdr_off;
  logic [ADDR_BUS-1:0]   fetch_addr;
  logic                  skip_base;
  logic                  oob;
  logic                  skip;
  logic                  unused_cfg;

  // Slot set is frozen while a pass is in flight.
  assign cfg_wr_en = cfg_we_i && ((state_q == FE_STATE_FREE) || (state_q == FE_STATE_DONE));

  field_extractor_cfg_regs #(
    .NUM_FIELDS (NUM_FIELDS),
    .IDX_W      (IDX_W)
  ) u_cfg_regs (
    .clk     (clk),
    .rst     (rst),
    .we      (cfg_wr_en),
    .wr_idx  (cfg_idx_i),
    .wr_data (cfg_data_i),
    .rd_idx  (idx_q),
    .rd_data (cfg_word)
  );

  assign cfg        = cfg_word;
  assign unused_cfg = ^cfg.rsvd;
  assign hdr_off    = (cfg.hdr_id < NUM_HDRS) ? hdrs_q[cfg.hdr_id[HDR_IDX_W-1:0]] : NO_HEADER;
  assign fetch_addr = ADDR_BUS'(hdr_off + WORD_WIDTH'(cfg.offset));
  assign skip_base  = !width_ok(cfg.width) || (cfg.hdr_id >= NUM_HDRS) || (hdr_off == NO_HEADER);
  assign skip       = skip_base || oob;

`ifdef FE_BOUNDS_CHECK_EN
  logic err_q;

  assign oob = (34'(fetch_addr) + 34'(cfg.width)) > 34'(PKT_MAX_LEN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if ((state_q == FE_STATE_FREE) && start_i) begin
      err_q <= 1'b0;
    end else if ((state_q == FE_STATE_SCAN) && !skip_base && oob) begin
      err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  logic unused_params;

  assign oob           = 1'b0;
  assign err_o         = 1'b0;
  assign unused_params = (PKT_MAX_LEN > 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FE_STATE_FREE;
      idx_q   <= '0;
      hdrs_q  <= '0;
      lanes_q <= '0;
      vld_q   <= '0;
      ready_q <= 1'b0;
      ce_q    <= 1'b0;
      addr_q  <= '0;
      width_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hdrs_q  <= hdrs_d;
      lanes_q <= lanes_d;
      vld_q   <= vld_d;
      ready_q <= ready_d;
      ce_q    <= ce_d;
      addr_q  <= addr_d;
      width_q <= width_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hdrs_d  = hdrs_q;
    lanes_d = lanes_q;
    vld_d   = vld_q;
    ready_d = ready_q;
    ce_d    = ce_q;
    addr_d  = addr_q;
    width_d = width_q;

    case (state_q)
      FE_STATE_FREE: begin
        if (start_i) begin
          hdrs_d  = parsed_hdrs_i;
          lanes_d = '0;
          vld_d   = '0;
          ready_d = 1'b0;
          idx_d   = '0;
          state_d = FE_STATE_SCAN;
        end
      end
      FE_STATE_SCAN: begin
        if (skip) begin
          if (idx_q == LAST_IDX) begin
            ready_d = 1'b1;
            state_d = FE_STATE_DONE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          ce_d    = 1'b1;
          addr_d  = fetch_addr;
          width_d = {1'b0, cfg.width};
          state_d = FE_STATE_WAIT;
        end
      end
      FE_STATE_WAIT: begin
        lanes_d[idx_q] = mem_data_i & width_mask(width_q[2:0]);
        vld_d[idx_q]   = 1'b1;
        ce_d           = 1'b0;
        addr_d         = '0;
        width_d        = '0;
        if (idx_q == LAST_IDX) begin
          ready_d = 1'b1;
          state_d = FE_STATE_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = FE_STATE_SCAN;
        end
      end
      FE_STATE_DONE: begin
        if (!start_i) begin
          ready_d = 1'b0;
          state_d = FE_STATE_FREE;
        end
      end
      default: begin
        state_d = FE_STATE_FREE;
        ce_d    = 1'b0;
        ready_d = 1'b0;
      end
    endcase
  end

  assign mem_ce_o        = ce_q;
  assign mem_we_o        = 1'b0;
  assign mem_addr_o      = addr_q;
  assign mem_width_o     = width_q;
  assign mem_data_o      = '0;
  assign extract_ready_o = ready_q;
  assign fields_o        = lanes_q;
  assign field_vld_o     = vld_q;

endmodule
